// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: combinational loads over a word array,
// with stores posted to a FIFO queue that forwards to loads and drains at a fixed rate.
module data_mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int QUEUE_DEPTH  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [63:0]                    MEM_ADDR,
    input  logic [63:0]                    WRITE_DATA,
    input  logic                           MEMWRITE,
    input  logic                           MEMREAD,
    output logic [63:0]                    READ_DATA,
    output logic [$clog2(QUEUE_DEPTH):0]   QUEUE_COUNT,
    output logic                           QUEUE_FULL,
    output logic                           ERR_OVERFLOW,
    output logic                           ERR_ALIGN
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WORDS  = 1 << ADDR_BITS;

    localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(QUEUE_DEPTH);
    localparam logic [DCNT_W-1:0] DRAIN_LAST_C = DCNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_r;
    logic [DCNT_W-1:0]    drain_cnt_r;
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;
    logic                 full_r;
    logic                 err_ovf_r;
    logic                 err_align_r;

    logic [ADDR_BITS-1:0] q_idx_r  [QUEUE_DEPTH];
    logic [63:0]          q_data_r [QUEUE_DEPTH];
    logic [63:0]          mem_r    [WORDS];

    logic [ADDR_BITS-1:0] idx_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 ovf_s;
    logic                 align_s;
    logic [CNT_W-1:0]     count_next_s;
    logic                 fwd_hit_s;
    logic [63:0]          fwd_data_s;
    logic                 unused_addr_s;

    // Word index wraps the array; bits above it are intentionally ignored.
    assign idx_s         = MEM_ADDR[ADDR_BITS+2:3];
    assign unused_addr_s = ^MEM_ADDR[63:ADDR_BITS+3];

    // Queue push/pop decisions and next occupancy for this cycle.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        ovf_s   = 1'b0;
        align_s = 1'b0;
        if (RESET) begin
            pop_s   = (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_LAST_C);
            // A full queue still takes a store when the head leaves at the same edge.
            push_s  = MEMWRITE && ((count_r != DEPTH_C) || pop_s);
            ovf_s   = MEMWRITE && !push_s;
            align_s = (MEMWRITE || MEMREAD) && (MEM_ADDR[2:0] != 3'b000);
        end else begin
            pop_s   = 1'b0;
            push_s  = 1'b0;
            ovf_s   = 1'b0;
            align_s = 1'b0;
        end
        count_next_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end

    // Store-to-load forwarding: scan oldest to newest so the newest match wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 64'h0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            if ((CNT_W'(k) < count_r) && (q_idx_r[head_r + PTR_W'(k)] == idx_s)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = q_data_r[head_r + PTR_W'(k)];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Load data path; a same-cycle store is not yet queued, so the old value is returned.
    always_comb begin
        READ_DATA = 64'h0;
        if (!RESET) begin
            READ_DATA = 64'h0;
        end else if (!MEMREAD) begin
            READ_DATA = 64'h0;
        end else if (fwd_hit_s) begin
            READ_DATA = fwd_data_s;
        end else begin
            READ_DATA = mem_r[idx_s];
        end
    end

    // Drain FSM, queue pointers, occupancy and sticky error flags.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {DCNT_W{1'b0}};
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            full_r      <= 1'b0;
            err_ovf_r   <= 1'b0;
            err_align_r <= 1'b0;
        end else begin
            head_r      <= pop_s  ? head_r + PTR_W'(1) : head_r;
            tail_r      <= push_s ? tail_r + PTR_W'(1) : tail_r;
            count_r     <= count_next_s;
            full_r      <= (count_next_s == DEPTH_C);
            err_ovf_r   <= err_ovf_r | ovf_s;
            err_align_r <= err_align_r | align_s;
            case (state_r)
                ST_IDLE: begin
                    drain_cnt_r <= {DCNT_W{1'b0}};
                    state_r     <= (count_next_s != {CNT_W{1'b0}}) ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    drain_cnt_r <= pop_s ? {DCNT_W{1'b0}} : drain_cnt_r + DCNT_W'(1);
                    state_r     <= (count_next_s != {CNT_W{1'b0}}) ? ST_DRAIN : ST_IDLE;
                end
                default: begin
                    drain_cnt_r <= {DCNT_W{1'b0}};
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Queue entry storage; stale entries beyond the count are never consulted.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            q_idx_r[tail_r]  <= idx_s;
            q_data_r[tail_r] <= WRITE_DATA;
        end
    end

    // Array write port, fed only by the committing queue head.
    always_ff @(posedge CLK) begin
        if (pop_s) begin
            mem_r[q_idx_r[head_r]] <= q_data_r[head_r];
        end
    end

    assign QUEUE_COUNT  = count_r;
    assign QUEUE_FULL   = full_r;
    assign ERR_OVERFLOW = err_ovf_r;
    assign ERR_ALIGN    = err_align_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;

    logic        CLK;
    logic        RESET;
    logic [63:0] MEM_ADDR;
    logic [63:0] WRITE_DATA;
    logic        MEMWRITE;
    logic        MEMREAD;
    logic [63:0] READ_DATA;
    logic [2:0]  QUEUE_COUNT;
    logic        QUEUE_FULL;
    logic        ERR_OVERFLOW;
    logic        ERR_ALIGN;

    int n_cmp;
    int n_err;

    data_mem_responder dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEM_ADDR     (MEM_ADDR),
        .WRITE_DATA   (WRITE_DATA),
        .MEMWRITE     (MEMWRITE),
        .MEMREAD      (MEMREAD),
        .READ_DATA    (READ_DATA),
        .QUEUE_COUNT  (QUEUE_COUNT),
        .QUEUE_FULL   (QUEUE_FULL),
        .ERR_OVERFLOW (ERR_OVERFLOW),
        .ERR_ALIGN    (ERR_ALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_cnt [8];
        exp_cnt = '{1, 2, 2, 3, 3, 4, 4, 4};
        n_cmp = 0;
        n_err = 0;
        RESET      = 1'b0;
        MEM_ADDR   = 64'h0;
        WRITE_DATA = 64'h0;
        MEMWRITE   = 1'b0;
        MEMREAD    = 1'b1;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_read_data", READ_DATA, 64'h0);
        check("rst_count", {61'h0, QUEUE_COUNT}, 64'h0);
        check("rst_full", {63'h0, QUEUE_FULL}, 64'h0);
        check("rst_ovf", {63'h0, ERR_OVERFLOW}, 64'h0);
        check("rst_align", {63'h0, ERR_ALIGN}, 64'h0);
        RESET   = 1'b1;
        MEMREAD = 1'b0;
        tick();

        // Preload words 0..15 with their own index through the store path
        for (int i = 0; i < 16; i++) begin
            MEM_ADDR   = 64'(i * 8);
            WRITE_DATA = 64'(i);
            MEMWRITE   = 1'b1;
            tick();
            MEMWRITE   = 1'b0;
            tick();
            tick();
        end
        check("preload_count", {61'h0, QUEUE_COUNT}, 64'h0);

        // Misaligned load
        MEMREAD  = 1'b1;
        MEM_ADDR = 64'h13;
        #1;
        check("align_read", READ_DATA, 64'h2);
        check("align_before_edge", {63'h0, ERR_ALIGN}, 64'h0);
        tick();
        MEMREAD  = 1'b0;
        check("align_set", {63'h0, ERR_ALIGN}, 64'h1);
        tick();
        tick();
        check("align_sticky", {63'h0, ERR_ALIGN}, 64'h1);

        // Store then forwarded load, then load from array after commit
        MEM_ADDR   = 64'h10;
        WRITE_DATA = 64'h1122334455667788;
        MEMWRITE   = 1'b1;
        tick();
        MEMWRITE = 1'b0;
        MEMREAD  = 1'b1;
        #1;
        check("fwd_read", READ_DATA, 64'h1122334455667788);
        check("fwd_count1", {61'h0, QUEUE_COUNT}, 64'h1);
        tick();
        check("fwd_count_e1", {61'h0, QUEUE_COUNT}, 64'h1);
        tick();
        check("commit_count", {61'h0, QUEUE_COUNT}, 64'h0);
        check("commit_read", READ_DATA, 64'h1122334455667788);
        MEMREAD = 1'b0;

        // Duplicate index: newest wins, oldest commits first
        MEM_ADDR   = 64'h8;
        WRITE_DATA = 64'hAAAA;
        MEMWRITE   = 1'b1;
        tick();
        check("dup_count1", {61'h0, QUEUE_COUNT}, 64'h1);
        WRITE_DATA = 64'hBBBB;
        tick();
        check("dup_count2", {61'h0, QUEUE_COUNT}, 64'h2);
        MEMWRITE = 1'b0;
        MEMREAD  = 1'b1;
        #1;
        check("dup_read_newest", READ_DATA, 64'hBBBB);
        tick();
        check("dup_count_mid", {61'h0, QUEUE_COUNT}, 64'h1);
        check("dup_read_mid", READ_DATA, 64'hBBBB);
        tick();
        tick();
        check("dup_count_end", {61'h0, QUEUE_COUNT}, 64'h0);
        check("dup_read_array", READ_DATA, 64'hBBBB);

        // Simultaneous load and store to the same word
        MEM_ADDR   = 64'h18;
        WRITE_DATA = 64'h77;
        MEMWRITE   = 1'b1;
        MEMREAD    = 1'b1;
        #1;
        check("rw_pre_value", READ_DATA, 64'h3);
        tick();
        MEMWRITE = 1'b0;
        #1;
        check("rw_post_value", READ_DATA, 64'h77);
        tick();
        tick();
        check("rw_count_end", {61'h0, QUEUE_COUNT}, 64'h0);
        check("rw_array_value", READ_DATA, 64'h77);
        MEMREAD = 1'b0;

        // Eight back-to-back stores into words 8..15; the eighth overflows
        for (int i = 0; i < 8; i++) begin
            MEM_ADDR   = 64'((8 + i) * 8);
            WRITE_DATA = 64'(32'h1000 + i);
            MEMWRITE   = 1'b1;
            tick();
            check($sformatf("burst_count_%0d", i + 1), {61'h0, QUEUE_COUNT}, 64'(exp_cnt[i]));
            check($sformatf("burst_full_%0d", i + 1), {63'h0, QUEUE_FULL}, (exp_cnt[i] == 4) ? 64'h1 : 64'h0);
            check($sformatf("burst_ovf_%0d", i + 1), {63'h0, ERR_OVERFLOW}, (i == 7) ? 64'h1 : 64'h0);
        end
        MEMWRITE = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("burst_drained", {61'h0, QUEUE_COUNT}, 64'h0);
        check("burst_ovf_sticky", {63'h0, ERR_OVERFLOW}, 64'h1);
        MEMREAD  = 1'b1;
        MEM_ADDR = 64'h40;
        #1;
        check("burst_word8", READ_DATA, 64'h1000);
        MEM_ADDR = 64'h58;
        #1;
        check("burst_word11", READ_DATA, 64'h1003);
        MEM_ADDR = 64'h70;
        #1;
        check("burst_word14", READ_DATA, 64'h1006);
        MEM_ADDR = 64'h78;
        #1;
        check("burst_dropped_word15", READ_DATA, 64'hF);
        MEMREAD = 1'b0;

        // Reset discards a pending store
        MEM_ADDR   = 64'h20;
        WRITE_DATA = 64'hDEAD;
        MEMWRITE   = 1'b1;
        tick();
        MEMWRITE = 1'b0;
        check("pre_rst_count", {61'h0, QUEUE_COUNT}, 64'h1);
        check("pre_rst_align", {63'h0, ERR_ALIGN}, 64'h1);
        RESET   = 1'b0;
        MEMREAD = 1'b1;
        #1;
        check("in_rst_read_zero", READ_DATA, 64'h0);
        tick();
        RESET = 1'b1;
        check("post_rst_count", {61'h0, QUEUE_COUNT}, 64'h0);
        check("post_rst_align", {63'h0, ERR_ALIGN}, 64'h0);
        check("post_rst_ovf", {63'h0, ERR_OVERFLOW}, 64'h0);
        #1;
        check("post_rst_read", READ_DATA, 64'h4);
        tick();
        tick();
        tick();
        check("post_rst_read_late", READ_DATA, 64'h4);
        MEMREAD = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
